view_controller: RTL and testbench

//  Display/LED formatter for the washing-machine controller. Takes the 3-bit machine

---
 rtl/view_controller.sv | 140 ++++++++++++++
 tb/tb_view_controller.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/view_controller.sv
// Display/LED formatter for the washing-machine controller: turns the machine state and the
// packed status word into three registered digit codes and a registered indicator-lamp bank.
module view_controller #(
    parameter int unsigned BLINK_DIV = 25_000_000,
    parameter logic [5:0]  BLANK     = 6'd63
) (
    input  logic        cp,
    input  logic        nCR,
    input  logic [2:0]  state,
    input  logic [25:0] msg,
    output logic [5:0]  showLeft,
    output logic [5:0]  showMiddle,
    output logic [5:0]  showRight,
    output logic [9:0]  LEDMsg
);
    localparam int unsigned   CW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_SET   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } mstate_e;

    mstate_e    st;
    logic [2:0] prog, wash_rem, rinse_rem, spin_rem, status, cur_rem;
    logic [3:0] total_rem, water;
    logic       unused_reserved;

    assign st              = mstate_e'(state);
    assign prog            = msg[25:23];
    assign total_rem       = msg[22:19];
    assign wash_rem        = msg[18:16];
    assign rinse_rem       = msg[15:13];
    assign spin_rem        = msg[12:10];
    assign water           = msg[9:6];
    assign unused_reserved = ^msg[5:3];
    assign status          = msg[2:0];

    // The phase currently running is the first non-empty one in wash -> rinse -> spin order.
    assign cur_rem = (wash_rem != 3'd0)  ? wash_rem  :
                     (rinse_rem != 3'd0) ? rinse_rem : spin_rem;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          blink_on_q, blink_on_d;
    logic [5:0]    left_q, left_d, mid_q, mid_d, right_q, right_d;
    logic [9:0]    led_q, led_d;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        cnt_d      = '0;
        blink_on_d = 1'b1;
        if (st == ST_PAUSE) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d      = '0;
                blink_on_d = ~blink_on_q;
            end else begin
                cnt_d      = cnt_q + CW'(1);
                blink_on_d = blink_on_q;
            end
        end
    end

    always_comb begin
        left_d  = BLANK;
        mid_d   = BLANK;
        right_d = BLANK;
        case (st)
            ST_SET: begin
                left_d  = {3'b000, prog};
                mid_d   = {2'b00, water};
                right_d = {2'b00, total_rem};
            end
            ST_RUN: begin
                left_d  = {2'b00, total_rem};
                mid_d   = {3'b000, cur_rem};
                right_d = {2'b00, water};
            end
            ST_PAUSE: begin
                if (blink_on_q) begin
                    left_d  = {2'b00, total_rem};
                    mid_d   = {3'b000, cur_rem};
                    right_d = {2'b00, water};
                end
            end
            ST_DONE: begin
                left_d  = 6'd0;
                mid_d   = 6'd0;
                right_d = 6'd0;
            end
            default: ;
        endcase
    end

    logic power, lamps_en, all_zero;

    always_comb begin
        power    = st inside {ST_SET, ST_RUN, ST_PAUSE, ST_DONE};
        lamps_en = st inside {ST_SET, ST_RUN, ST_PAUSE};
        all_zero = (total_rem == 4'd0) && (wash_rem == 3'd0) &&
                   (rinse_rem == 3'd0) && (spin_rem == 3'd0);
        led_d    = {power,
                    st == ST_RUN,
                    st == ST_PAUSE,
                    (st == ST_DONE) || ((st == ST_RUN) && all_zero),
                    lamps_en && (wash_rem != 3'd0),
                    lamps_en && (rinse_rem != 3'd0),
                    lamps_en && (spin_rem != 3'd0),
                    power ? status : 3'b000};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the values
    // from before the edge, independent of process evaluation order.
    always_ff @(posedge cp or negedge nCR) begin
        if (!nCR) begin
            cnt_q      <= '0;
            blink_on_q <= 1'b1;
            left_q     <= BLANK;
            mid_q      <= BLANK;
            right_q    <= BLANK;
            led_q      <= '0;
        end else begin
            cnt_q      <= cnt_d;
            blink_on_q <= blink_on_d;
            left_q     <= left_d;
            mid_q      <= mid_d;
            right_q    <= right_d;
            led_q      <= led_d;
        end
    end

    assign showLeft   = left_q;
    assign showMiddle = mid_q;
    assign showRight  = right_q;
    assign LEDMsg     = led_q;

endmodule

// File: tb/tb_view_controller.sv
// Self-checking bench for view_controller: a behavioural model derived from the display rules
// is compared every cycle, and hand-computed literal vectors pin the model itself.
module tb_view_controller;
    localparam int         BLINK_DIV = 4;
    localparam logic [5:0] BLANK     = 6'd63;
    localparam logic [27:0] ALL_BLANK = {BLANK, BLANK, BLANK, 10'd0};

    localparam logic [25:0] MSG_A = 26'b011_1010_100_101_011_1000_100_101;
    localparam logic [25:0] MSG_B = 26'b000_0000_100_101_011_1000_100_101;
    localparam logic [25:0] MSG_C = 26'b000_0000_000_000_000_0000_000_100;
    localparam logic [25:0] MSG_D = 26'b010_0111_000_101_011_0110_000_011;
    localparam logic [25:0] MSG_E = 26'b001_0000_000_000_011_0101_111_110;

    logic        cp    = 1'b0;
    logic        nCR   = 1'b1;
    logic [2:0]  state = 3'd0;
    logic [25:0] msg   = '0;
    logic [5:0]  showLeft, showMiddle, showRight;
    logic [9:0]  LEDMsg;
    logic [27:0] dut_out;

    int checks   = 0;
    int failures = 0;

    view_controller #(.BLINK_DIV(BLINK_DIV), .BLANK(BLANK)) dut (
        .cp(cp), .nCR(nCR), .state(state), .msg(msg),
        .showLeft(showLeft), .showMiddle(showMiddle), .showRight(showRight),
        .LEDMsg(LEDMsg)
    );

    always #5 cp = ~cp;
    assign dut_out = {showLeft, showMiddle, showRight, LEDMsg};

    // Model: k is the 1-based count of consecutive edges spent in PAUSE (0 elsewhere).
    function automatic logic [27:0] model(input logic [2:0] st, input logic [25:0] m, input int k);
        int prog, tot, wash, rinse, spin, water, cur;
        bit vis;
        logic [5:0] l, mi, r;
        logic [9:0] led;
        prog  = int'(m[25:23]);
        tot   = int'(m[22:19]);
        wash  = int'(m[18:16]);
        rinse = int'(m[15:13]);
        spin  = int'(m[12:10]);
        water = int'(m[9:6]);
        cur   = (wash != 0) ? wash : (rinse != 0) ? rinse : spin;
        vis   = (k <= 0) || ((((k - 1) / BLINK_DIV) % 2) == 0);
        l = BLANK; mi = BLANK; r = BLANK; led = '0;
        if (st >= 3'd1 && st <= 3'd4) begin
            led[9]   = 1'b1;
            led[2:0] = m[2:0];
        end
        if (st >= 3'd1 && st <= 3'd3) led[5:3] = {wash != 0, rinse != 0, spin != 0};
        led[8] = (st == 3'd2);
        led[7] = (st == 3'd3);
        led[6] = (st == 3'd4) || ((st == 3'd2) && (tot + wash + rinse + spin == 0));
        case (st)
            3'd1: begin l = 6'(prog); mi = 6'(water); r = 6'(tot); end
            3'd2: begin l = 6'(tot); mi = 6'(cur); r = 6'(water); end
            3'd3: if (vis) begin l = 6'(tot); mi = 6'(cur); r = 6'(water); end
            3'd4: begin l = 6'd0; mi = 6'd0; r = 6'd0; end
            default: ;
        endcase
        return {l, mi, r, led};
    endfunction

    logic [27:0] exp_out     = ALL_BLANK;
    int          pause_edges = 0;

    always @(posedge cp or negedge nCR) begin
        if (!nCR) begin
            exp_out     <= ALL_BLANK;
            pause_edges <= 0;
        end else begin
            exp_out     <= model(state, msg, (state == 3'd3) ? pause_edges + 1 : 0);
            pause_edges <= (state == 3'd3) ? pause_edges + 1 : 0;
        end
    end

    logic        lit_en   = 1'b0;
    logic [27:0] lit_exp  = '0;
    string       lit_name = "";

    task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got L=%0d M=%0d R=%0d LED=%b, expected L=%0d M=%0d R=%0d LED=%b",
                     name, $time, act[27:22], act[21:16], act[15:10], act[9:0],
                     exp[27:22], exp[21:16], exp[15:10], exp[9:0]);
        end
    endtask

    // Single compare process: outputs are sampled on the falling edge, away from cp rising.
    always @(negedge cp) begin
        check("model", dut_out, exp_out);
        if (lit_en) check(lit_name, dut_out, lit_exp);
    end

    task automatic apply(input logic [2:0] st, input logic [25:0] m,
                         input logic en, input logic [27:0] e, input string name);
        @(negedge cp);
        #2;
        state    = st;
        msg      = m;
        lit_en   = en;
        lit_exp  = e;
        lit_name = name;
    endtask

    localparam logic [27:0] PAUSE_VIS   = {6'd10, 6'd4, 6'd8, 10'b10_1_0_111_101};
    localparam logic [27:0] PAUSE_BLANK = {BLANK, BLANK, BLANK, 10'b10_1_0_111_101};

    initial begin
        logic [9:0] vis_pat;
        logic [2:0] rst;
        int         dwell;
        vis_pat = 10'b11_0000_1111;

        #1 nCR = 1'b0;
        apply(3'd1, MSG_A, 1'b1, ALL_BLANK, "reset_hold");
        @(negedge cp);
        #2;
        nCR      = 1'b1;
        lit_en   = 1'b1;
        lit_exp  = {6'd3, 6'd8, 6'd10, 10'b10_0_0_111_101};
        lit_name = "set_decode";

        apply(3'd2, MSG_A, 1'b1, {6'd10, 6'd4, 6'd8, 10'b11_0_0_111_101}, "run_decode");
        apply(3'd2, MSG_B, 1'b1, {6'd0, 6'd4, 6'd8, 10'b11_0_0_111_101}, "run_total0");
        apply(3'd2, MSG_C, 1'b1, {6'd0, 6'd0, 6'd0, 10'b11_0_1_000_100}, "run_all_zero");
        apply(3'd2, MSG_D, 1'b1, {6'd7, 6'd5, 6'd6, 10'b11_0_0_011_011}, "run_cur_rinse");
        apply(3'd2, MSG_E, 1'b1, {6'd0, 6'd3, 6'd5, 10'b11_0_0_001_110}, "run_cur_spin");
        apply(3'd1, MSG_E, 1'b1, {6'd1, 6'd5, 6'd0, 10'b10_0_0_001_110}, "set_msg_e");

        for (int i = 0; i < 10; i++)
            apply(3'd3, MSG_A, 1'b1, vis_pat[i] ? PAUSE_VIS : PAUSE_BLANK, "pause_blink");
        apply(3'd2, MSG_A, 1'b1, {6'd10, 6'd4, 6'd8, 10'b11_0_0_111_101}, "pause_exit");
        for (int i = 0; i < 5; i++)
            apply(3'd3, MSG_A, 1'b1, vis_pat[i] ? PAUSE_VIS : PAUSE_BLANK, "pause_reentry");

        apply(3'd4, MSG_A, 1'b1, {6'd0, 6'd0, 6'd0, 10'b10_0_1_000_101}, "done_decode");
        apply(3'd0, MSG_A, 1'b1, ALL_BLANK, "off_decode");
        apply(3'd6, MSG_A, 1'b1, ALL_BLANK, "state6_off");
        apply(3'd5, MSG_D, 1'b1, ALL_BLANK, "state5_off");
        apply(3'd7, MSG_E, 1'b1, ALL_BLANK, "state7_off");

        // Reset asserted mid-cycle while in PAUSE showing blank: must clear before any cp edge.
        for (int i = 0; i < 6; i++)
            apply(3'd3, MSG_A, 1'b1, vis_pat[i] ? PAUSE_VIS : PAUSE_BLANK, "pause_pre_reset");
        @(posedge cp);
        #1;
        nCR      = 1'b0;
        lit_en   = 1'b1;
        lit_exp  = ALL_BLANK;
        lit_name = "async_reset";
        @(negedge cp);
        #2;
        nCR = 1'b1;
        lit_exp  = PAUSE_VIS;
        lit_name = "pause_after_reset";
        apply(3'd3, MSG_A, 1'b1, PAUSE_VIS, "pause_after_reset2");

        for (int n = 0; n < 80; n += dwell) begin
            rst   = 3'($urandom_range(0, 7));
            dwell = int'($urandom_range(1, 10));
            for (int j = 0; j < dwell; j++)
                apply(rst, 26'($urandom()), 1'b0, '0, "");
        end

        apply(3'd0, '0, 1'b0, '0, "");
        @(negedge cp);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
